ps2_scan_rx: RTL

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

---
 rtl/ps2_scan_rx.sv | 97 +++++++++
 1 files changed

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard frame receiver and scan-code decoder with E0/F0 prefix stripping
// Ports: clock/resetn (async active-low) system clock and reset; ps2_clk/ps2_dat raw keyboard lines;
//        code_valid strobe with code/code_ext/code_break; frame_err strobe on stop/parity/timeout errors.
// Build option: define PS2_PARITY_CHECK_EN to enforce odd parity on each frame.
module ps2_scan_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_break,
  output logic       frame_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, dat_sync;
  logic clk_q, ext, brk;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [CW-1:0] idle_cnt;
  logic dat, fall, sat, timeout, par_ok, stop_ok, stop_bad, is_code;
  assign dat = dat_sync[1];
  assign fall = clk_q & ~clk_sync[1];
  assign sat = idle_cnt == CW'(TIMEOUT_CYCLES);
  assign timeout = (state != IDLE) && sat;
  assign is_code = stop_ok && shift != 8'hE0 && shift != 8'hF0;
`ifdef PS2_PARITY_CHECK_EN
  logic par;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) par <= 1'b0;
    else if (fall && state == PARITY) par <= dat;
  assign par_ok = ^{shift, par};
`else
  assign par_ok = 1'b1;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    stop_ok = 1'b0;
    stop_bad = 1'b0;
    if (timeout) state_n = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_n = dat ? IDLE : DATA;
        DATA:    state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          stop_ok = dat & par_ok;
          stop_bad = ~(dat & par_ok);
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_q <= 1'b1;
      bit_cnt <= '0;
      shift <= '0;
      idle_cnt <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      code_valid <= 1'b0;
      frame_err <= 1'b0;
      code <= '0;
      code_ext <= 1'b0;
      code_break <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_q <= clk_sync[1];
      idle_cnt <= fall ? '0 : sat ? idle_cnt : idle_cnt + 1'b1;
      if (fall && state == DATA) begin
        shift <= {dat, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (timeout) bit_cnt <= '0;
      code_valid <= is_code;
      frame_err <= timeout | stop_bad;
      if (is_code) begin
        code <= shift;
        code_ext <= ext;
        code_break <= brk;
      end
      ext <= (timeout | stop_bad | is_code) ? 1'b0 : (stop_ok && shift == 8'hE0) ? 1'b1 : ext;
      brk <= (timeout | stop_bad | is_code) ? 1'b0 : (stop_ok && shift == 8'hF0) ? 1'b1 : brk;
    end
endmodule
